// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the unified RAM arbiter.
// Holds the read-owner tag encoding and the default bus widths.
// Imported by the arbiter top and its priority encoder.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  // Who owns the read that is currently crossing the RAM's one-cycle latency.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_HOST  = 2'd1,
    TAG_DATA  = 2'd2,
    TAG_FETCH = 2'd3
  } owner_tag_e;

  // One-hot grant vector, at most one bit set.
  typedef struct packed {
    logic host;
    logic data;
    logic fetch;
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_arbiter.
// slave = arbiter view; master = core/host/RAM side view.
// Grants are same-cycle; read data returns one cycle after a read grant.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::MEM_ADDR_W,
  parameter int DATA_W = mem_arbiter_pkg::MEM_DATA_W
);

  logic              working;

  logic              h_req;
  logic              h_wr;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;

  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] f_instr;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wEn;
  logic              ram_rEn;
  logic [DATA_W-1:0] ram_wDat;
  logic [DATA_W-1:0] ram_rDat;

  modport slave (
    input  working,
    input  h_req, h_wr, h_addr, h_wdata,
    output h_gnt, h_rvalid,
    input  d_req, d_wr, d_addr, d_wdata,
    output d_gnt, d_rvalid,
    input  f_req, f_addr,
    output f_gnt, f_rvalid,
    output rdata, f_instr,
    output ram_addr, ram_wEn, ram_rEn, ram_wDat,
    input  ram_rDat
  );

  modport master (
    output working,
    output h_req, h_wr, h_addr, h_wdata,
    input  h_gnt, h_rvalid,
    output d_req, d_wr, d_addr, d_wdata,
    input  d_gnt, d_rvalid,
    output f_req, f_addr,
    input  f_gnt, f_rvalid,
    input  rdata, f_instr,
    input  ram_addr, ram_wEn, ram_rEn, ram_wDat,
    output ram_rDat
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Three-way priority encoder: host > data > fetch, with fetch-over-data override.
// Latency: purely combinational.
// Backpressure: losers simply see no grant and must hold their request.
module mem_arb_prio
  import mem_arbiter_pkg::*;
(
  input  logic h_req,
  input  logic d_req,
  input  logic f_req,
  input  logic fetch_first,
  output gnt_t gnt
);

  // Fixed priority; the override only reorders data and fetch, never host.
  always_comb begin
    gnt = '0;
    if (h_req) begin
      gnt.host = 1'b1;
    end else if (f_req && fetch_first) begin
      gnt.fetch = 1'b1;
    end else if (d_req) begin
      gnt.data = 1'b1;
    end else if (f_req) begin
      gnt.fetch = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified RAM between host loader, data port and fetch.
// Latency: grant same cycle; read data/rvalid one cycle after grant; writes commit at grant edge.
// Backpressure: ungranted requesters hold their request; no pending state is stored here.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  logic              h_elig;
  logic              d_elig;
  logic              f_elig;
  logic              fetch_first;
  gnt_t              gnt;

  owner_tag_e        tag_q;
  owner_tag_e        tag_d;
  logic [DATA_W-1:0] f_instr_q;
  logic [DATA_W-1:0] f_instr_d;

  logic              h_rv;
  logic              d_rv;
  logic              f_rv;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdat_mux;
  logic              wen_mux;
  logic              ren_mux;

  // Host only while halted, core ports only while running; nothing during reset.
  assign h_elig = bus.h_req & ~bus.working & ~reset;
  assign d_elig = bus.d_req &  bus.working & ~reset;
  assign f_elig = bus.f_req &  bus.working & ~reset;

  mem_arb_prio u_prio (
    .h_req       (h_elig),
    .d_req       (d_elig),
    .f_req       (f_elig),
    .fetch_first (fetch_first),
    .gnt         (gnt)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // Count cycles fetch asks but loses; clear on a fetch grant or when halted.
  always_comb begin
    starve_d = starve_q;
    if (!bus.working || gnt.fetch) begin
      starve_d = '0;
    end else if (bus.f_req && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign fetch_first = bus.working & (starve_q == STARVE_LIM);
`else
  assign fetch_first = 1'b0;
`endif

  // Steer the winner onto the RAM and remember who owns a read.
  always_comb begin
    addr_mux = '0;
    wdat_mux = '0;
    wen_mux  = 1'b0;
    ren_mux  = 1'b0;
    tag_d    = TAG_NONE;
    if (gnt.host) begin
      addr_mux = bus.h_addr;
      wen_mux  = bus.h_wr;
      ren_mux  = ~bus.h_wr;
      wdat_mux = bus.h_wr ? bus.h_wdata : '0;
      tag_d    = bus.h_wr ? TAG_NONE : TAG_HOST;
    end else if (gnt.data) begin
      addr_mux = bus.d_addr;
      wen_mux  = bus.d_wr;
      ren_mux  = ~bus.d_wr;
      wdat_mux = bus.d_wr ? bus.d_wdata : '0;
      tag_d    = bus.d_wr ? TAG_NONE : TAG_DATA;
    end else if (gnt.fetch) begin
      addr_mux = bus.f_addr;
      ren_mux  = 1'b1;
      tag_d    = TAG_FETCH;
    end
  end

  // Owner tag: one-deep pipeline matching the RAM read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Reset masks a read returning in the same cycle.
  assign h_rv = (tag_q == TAG_HOST)  & ~reset;
  assign d_rv = (tag_q == TAG_DATA)  & ~reset;
  assign f_rv = (tag_q == TAG_FETCH) & ~reset;

  // Capture returning instructions so the word survives fetch stalls.
  always_comb begin
    f_instr_d = f_instr_q;
    if (f_rv) begin
      f_instr_d = bus.ram_rDat;
    end
  end

  // Held-instruction register.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_instr_q <= '0;
    end else begin
      f_instr_q <= f_instr_d;
    end
  end

  assign bus.h_gnt    = gnt.host;
  assign bus.d_gnt    = gnt.data;
  assign bus.f_gnt    = gnt.fetch;
  assign bus.h_rvalid = h_rv;
  assign bus.d_rvalid = d_rv;
  assign bus.f_rvalid = f_rv;
  assign bus.rdata    = (h_rv | d_rv | f_rv) ? bus.ram_rDat : '0;
  assign bus.f_instr  = f_instr_q;
  assign bus.ram_addr = addr_mux;
  assign bus.ram_wEn  = wen_mux;
  assign bus.ram_rEn  = ren_mux;
  assign bus.ram_wDat = wdat_mux;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural one-cycle RAM.
// Expected read results come from a shadow memory and go through a queue.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    owner;
    logic [DW-1:0] data;
  } exp_t;

  logic clock;
  logic reset;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural single-port RAM, read data one cycle after rEn.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_rdat_q;
  always @(posedge clock) begin
    if (bus.ram_wEn) ram[bus.ram_addr] <= bus.ram_wDat;
    if (bus.ram_rEn) ram_rdat_q <= ram[bus.ram_addr];
  end
  assign bus.ram_rDat = ram_rdat_q;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  exp_t sb [$];
  logic [AW-1:0] pre_a [4];
  logic [DW-1:0] pre_d [4];

  function automatic logic [2:0] owner_vec(input logic [1:0] t);
    return {t == TAG_HOST, t == TAG_DATA, t == TAG_FETCH};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.h_req = 1'b0; bus.h_wr = 1'b0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    bus.f_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.working = 1'b1;
    bus.h_req = 1'b1; bus.d_req = 1'b1; bus.f_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      checks++;
      if ({bus.h_gnt, bus.d_gnt, bus.f_gnt, bus.h_rvalid, bus.d_rvalid, bus.f_rvalid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: gnt/rvalid=%b expected 000000", i,
                 {bus.h_gnt, bus.d_gnt, bus.f_gnt, bus.h_rvalid, bus.d_rvalid, bus.f_rvalid});
      end
    end
    checks++;
    if (bus.f_instr !== '0) begin
      errors++; $display("FAIL reset_f_instr: got %h expected 0", bus.f_instr);
    end
    cyc(); reset = 1'b0; idle(); #1;
    checks++;
    if ({bus.ram_addr, bus.ram_wEn, bus.ram_rEn, bus.ram_wDat} !== '0) begin
      errors++;
      $display("FAIL idle_ram_ctrl: addr=%h wEn=%b rEn=%b wDat=%h expected all 0",
               bus.ram_addr, bus.ram_wEn, bus.ram_rEn, bus.ram_wDat);
    end
  endtask

  task automatic test_host_load();
    exp_t e;
    pre_a[0] = 9'h005; pre_d[0] = 32'hDEADBEEF;
    pre_a[1] = 9'h010; pre_d[1] = 32'h0000_0011;
    pre_a[2] = 9'h000; pre_d[2] = 32'h0000_0013;
    pre_a[3] = 9'h020; pre_d[3] = 32'h0BAD_0BAD;
    bus.working = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.h_req = 1'b1; bus.h_wr = 1'b1; bus.h_addr = pre_a[i]; bus.h_wdata = pre_d[i];
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 9'h1FF;
      bus.f_req = 1'b1; bus.f_addr = 9'h1FE;
      #1;
      checks++;
      if ({bus.h_gnt, bus.d_gnt, bus.f_gnt, bus.ram_wEn, bus.ram_rEn, bus.ram_addr, bus.ram_wDat}
          !== {5'b10010, pre_a[i], pre_d[i]}) begin
        errors++;
        $display("FAIL host_write%0d: gnt=%b wEn=%b rEn=%b addr=%h wDat=%h expected gnt=100 wEn=1 rEn=0 addr=%h wDat=%h",
                 i, {bus.h_gnt, bus.d_gnt, bus.f_gnt}, bus.ram_wEn, bus.ram_rEn,
                 bus.ram_addr, bus.ram_wDat, pre_a[i], pre_d[i]);
      end
      shadow[pre_a[i]] = pre_d[i];
    end
    // Host read-back while halted.
    cyc();
    idle(); bus.h_req = 1'b1; bus.h_wr = 1'b0; bus.h_addr = 9'h005;
    #1;
    checks++;
    if ({bus.h_gnt, bus.ram_rEn, bus.ram_wEn} !== 3'b110) begin
      errors++; $display("FAIL host_read_gnt: gnt/rEn/wEn=%b expected 110", {bus.h_gnt, bus.ram_rEn, bus.ram_wEn});
    end
    sb.push_back('{TAG_HOST, shadow[9'h005]});
    cyc();
    // Host is ignored once the core runs.
    bus.working = 1'b1; bus.h_wr = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 9'h005;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
        errors++; $display("FAIL host_read_data: rvalid=%b rdata=%h expected %b %h",
                           {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
      end
    end
    checks++;
    if ({bus.h_gnt, bus.d_gnt, bus.f_gnt, bus.ram_wEn} !== 4'b0010) begin
      errors++; $display("FAIL fetch_after_load_gnt: gnt/wEn=%b expected 0010", {bus.h_gnt, bus.d_gnt, bus.f_gnt, bus.ram_wEn});
    end
    sb.push_back('{TAG_FETCH, shadow[9'h005]});
    cyc();
    idle(); #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
        errors++; $display("FAIL fetch_after_load_data: rvalid=%b rdata=%h expected %b %h",
                           {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
      end
    end
    cyc();
    checks++;
    if (bus.f_instr !== 32'hDEADBEEF) begin
      errors++; $display("FAIL f_instr_load: got %h expected deadbeef", bus.f_instr);
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    bus.working = 1'b1;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 9'h010;
    bus.f_req = 1'b1; bus.f_addr = 9'h000;
    #1;
    checks++;
    if ({bus.h_gnt, bus.d_gnt, bus.f_gnt} !== 3'b010) begin
      errors++; $display("FAIL conflict_gnt: gnt=%b expected 010", {bus.h_gnt, bus.d_gnt, bus.f_gnt});
    end
    sb.push_back('{TAG_DATA, shadow[9'h010]});
    cyc();
    bus.d_req = 1'b0;   // fetch keeps holding its request
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
        errors++; $display("FAIL conflict_data: rvalid=%b rdata=%h expected %b %h",
                           {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
      end
    end
    checks++;
    if (bus.f_instr !== 32'hDEADBEEF) begin
      errors++; $display("FAIL conflict_f_instr_hold: got %h expected deadbeef", bus.f_instr);
    end
    checks++;
    if (bus.f_gnt !== 1'b1) begin
      errors++; $display("FAIL conflict_fetch_retry: f_gnt=%b expected 1", bus.f_gnt);
    end
    sb.push_back('{TAG_FETCH, shadow[9'h000]});
    cyc();
    idle(); #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
        errors++; $display("FAIL conflict_fetch_data: rvalid=%b rdata=%h expected %b %h",
                           {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
      end
    end
    cyc();
    checks++;
    if (bus.f_instr !== 32'h13) begin
      errors++; $display("FAIL conflict_f_instr_new: got %h expected 13", bus.f_instr);
    end
  endtask

  task automatic test_store();
    exp_t e;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 9'h020; bus.d_wdata = 32'h5A;
    #1;
    checks++;
    if ({bus.d_gnt, bus.ram_wEn, bus.ram_rEn, bus.ram_addr, bus.ram_wDat} !== {3'b110, 9'h020, 32'h5A}) begin
      errors++; $display("FAIL store_gnt: gnt=%b wEn=%b rEn=%b addr=%h wDat=%h expected 1 1 0 020 0000005a",
                         bus.d_gnt, bus.ram_wEn, bus.ram_rEn, bus.ram_addr, bus.ram_wDat);
    end
    shadow[9'h020] = 32'h5A;
    cyc();
    bus.d_wr = 1'b0;
    #1;
    checks++;
    if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid} !== 3'b000) begin
      errors++; $display("FAIL store_no_rvalid: rvalid=%b expected 000", {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid});
    end
    sb.push_back('{TAG_DATA, shadow[9'h020]});
    cyc();
    idle(); #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
        errors++; $display("FAIL store_readback: rvalid=%b rdata=%h expected %b %h",
                           {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = pre_a[i];
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
          errors++; $display("FAIL b2b_data%0d: rvalid=%b rdata=%h expected %b %h", i,
                             {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
        end
      end
      checks++;
      if (bus.d_gnt !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt%0d: d_gnt=%b expected 1", i, bus.d_gnt);
      end
      sb.push_back('{TAG_DATA, shadow[pre_a[i]]});
    end
    // Halt while the last read is in flight: it must still complete.
    cyc();
    bus.working = 1'b0;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
        errors++; $display("FAIL halt_inflight: rvalid=%b rdata=%h expected %b %h",
                           {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
      end
    end
    checks++;
    if (bus.d_gnt !== 1'b0) begin
      errors++; $display("FAIL halt_data_blocked: d_gnt=%b expected 0", bus.d_gnt);
    end
    cyc();
    idle(); bus.working = 1'b1;
  endtask

  task automatic test_starvation();
    exp_t e;
    logic want_f;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 9'h010;
    bus.f_req = 1'b1; bus.f_addr = 9'h005;
    for (int k = 1; k <= 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      want_f = (k % 5) == 0;
`else
      want_f = 1'b0;
`endif
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
          errors++; $display("FAIL starve_data%0d: rvalid=%b rdata=%h expected %b %h", k,
                             {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
        end
      end
      checks++;
      if ({bus.d_gnt, bus.f_gnt} !== {~want_f, want_f}) begin
        errors++; $display("FAIL starve_gnt%0d: d/f gnt=%b expected %b", k, {bus.d_gnt, bus.f_gnt}, {~want_f, want_f});
      end
      if (want_f) sb.push_back('{TAG_FETCH, shadow[9'h005]});
      else        sb.push_back('{TAG_DATA, shadow[9'h010]});
      cyc();
    end
    idle(); #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid, bus.rdata} !== {owner_vec(e.owner), e.data}) begin
        errors++; $display("FAIL starve_last: rvalid=%b rdata=%h expected %b %h",
                           {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid}, bus.rdata, owner_vec(e.owner), e.data);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    cyc();
    bus.f_req = 1'b1; bus.f_addr = 9'h020;
    #1;
    checks++;
    if (bus.f_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_mid_gnt: f_gnt=%b expected 1", bus.f_gnt);
    end
    cyc();
    reset = 1'b1; idle();
    #1;
    checks++;
    if ({bus.h_rvalid, bus.d_rvalid, bus.f_rvalid} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_rvalid: rvalid=%b expected 000", {bus.h_rvalid, bus.d_rvalid, bus.f_rvalid});
    end
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.f_rvalid, bus.f_instr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_mid_f_instr: f_rvalid=%b f_instr=%h expected 0 00000000", bus.f_rvalid, bus.f_instr);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.working = 1'b0;
    bus.h_req = 1'b0; bus.h_wr = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.f_req = 1'b0; bus.f_addr = '0;
    test_reset();
    test_host_load();
    test_conflict();
    test_store();
    test_back_to_back();
    test_starvation();
    test_reset_mid_read();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter and sequencer that shares the unified instruction/data RAM between three requesters: the host loader (program/data download while the core is halted), the data port (load/store from the execute stage) and the instruction-fetch port. It sits between the core pipeline and the RAM instance, replacing ad-hoc address/enable muxing with explicit request/grant handshakes. It tracks read ownership across the RAM's one-cycle read latency and holds the last fetched instruction while fetch is stalled.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, RAM data width
- STARVE_MAX, 4, consecutive fetch denials before fetch is promoted (see Configuration); range 1..15
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- working  in  1  1 = core running (host port ignored); 0 = halted (only host port served)
- h_req / h_wr  in  1 / 1  host request; 1 = write, 0 = read
- h_addr / h_wdata  in  ADDR_W / DATA_W  host address / write data
- h_gnt  out  1  host granted this cycle
- h_rvalid  out  1  host read data valid
- d_req / d_wr  in  1 / 1  data-port request (LW: d_wr=0, SW: d_wr=1)
- d_addr / d_wdata  in  ADDR_W / DATA_W  data address / store data
- d_gnt  out  1  data port granted this cycle
- d_rvalid  out  1  load data valid
- f_req  in  1  fetch request (read only)
- f_addr  in  ADDR_W  fetch address (PC)
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch data valid
- rdata  out  DATA_W  read data, shared by all read ports
- f_instr  out  DATA_W  held instruction word
- ram_addr  out  ADDR_W  to RAM
- ram_wEn / ram_rEn  out  1 / 1  to RAM
- ram_wDat  out  DATA_W  to RAM
- ram_rDat  in  DATA_W  from RAM; valid one cycle after the read-enable cycle

## Operation
- Eligibility: host only when working=0; data and fetch only when working=1.
- Priority: host > data > fetch, except for the starvation override.
- Grant is combinational in the request cycle. At most one gnt is high per cycle.
- The granted requester drives ram_addr. ram_wEn equals the granted wr. ram_rEn is high on any granted read.
- With no grant: ram_addr=0, ram_wEn=0, ram_rEn=0, ram_wDat=0.
- Writes complete in the grant cycle. No rvalid is issued for a write.
- A read grant loads a 2-bit owner tag (NONE/HOST/DATA/FETCH). Next cycle:
  - the owner's rvalid = 1;
  - rdata = ram_rDat (combinational pass-through);
  - tag returns to NONE unless another read is granted.
- Back-to-back reads are allowed every cycle; the tag pipelines one deep.
- f_instr loads ram_rDat whenever f_rvalid=1 and holds otherwise, so it stays stable through data-port stalls.
- rdata is undefined (0 recommended) when no rvalid is high.
- If working falls while a read is in flight, the read still completes and rvalid is delivered.
- A request that is not granted must be held by the requester. The arbiter stores no pending requests.

## Timing
- Reset values: all gnt=0, all rvalid=0, tag=NONE, f_instr=0, starvation counter=0.
- Read latency: grant in cycle T, rvalid/rdata in T+1.
- Write latency: committed at the clock edge ending T.
- Reset asserted in the cycle after a read grant: rvalid is forced to 0 and the tag is cleared. Reset has priority over everything.
- Simultaneous d_req and f_req: d_gnt=1, f_gnt=0, and fetch is stalled one cycle.
- Counter (when enabled): 4 bits, +1 on each cycle with f_req && !f_gnt && working, cleared on f_gnt or working=0, saturates at STARVE_MAX.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: when the counter equals STARVE_MAX, fetch beats data for one grant and the counter then clears. Host is never overridden.
- Undefined: strict priority, so a continuously requesting data port can starve fetch indefinitely. The counter logic is not instantiated.

## Structure
- Shared package: owner-tag encoding (TAG_NONE=0, TAG_HOST=1, TAG_DATA=2, TAG_FETCH=3) and the default ADDR_W/DATA_W constants.
- One natural sub-module: mem_arb_prio, a combinational 3-way priority encoder with override input, returning one-hot grants.
- Tag register, f_instr holding register and starvation counter live in mem_arbiter.

## Test plan
- Reset: hold reset 2 cycles with all req=1 -> all gnt=0, all rvalid=0, f_instr=0.
- Host load: working=0, h_req=1, h_wr=1, addr 0x005, data 0xDEADBEEF -> h_gnt=1, ram_wEn=1. Then working=1, f_req at 0x005 -> f_rvalid next cycle, f_instr=0xDEADBEEF.
- Conflict: d_req read at 0x010 (holding 0x11) and f_req at 0x000, same cycle -> d_gnt=1, f_gnt=0. Next cycle d_rvalid=1 with rdata=0x11, and f_instr is unchanged.
- Store: d_req=1, d_wr=1, addr 0x020, data 0x5A -> d_gnt=1 and no d_rvalid. A later read of 0x020 returns 0x5A.
- Starvation (macro on, STARVE_MAX=4): d_req and f_req held high -> fetch granted on the 5th cycle, then data resumes. Macro off -> f_gnt stays 0.
- Reset mid-read: f_gnt in cycle T, reset in T+1 -> f_rvalid=0 in T+1 and f_instr=0.
